idu_scoreboard_stage: RTL
=========================

// Module: idu_scoreboard_stage
// PURPOSE
// - Parametrised decode stage: registers one instruction per cycle between fetch and execute.
// - Holds the integer register file with x0 tied to zero, extracts immediates, and keeps a per-register busy scoreboard.
// - Stalls fetch on RAW/WAW hazards; valid/ready on both sides; single-cycle flush for redirects.
// PARAMETERS
// - XLEN  32  data/PC width
// - NREG  32  architectural registers (16 = RV32E); index width RW = $clog2(NREG)
// PORTS
// - clk            in   1     clock
// - rst            in   1     synchronous reset, active-high
// - flush          in   1     drop instruction held in output register
// - in_valid       in   1     fetch offers instruction
// - in_ready       out  1     stage accepts instruction this cycle
// - in_inst        in   32    instruction word
// - in_pc          in   XLEN  instruction PC
// - out_valid      out  1     decoded instruction available
// - out_ready      in   1     execute consumes it
// - out_inst       out  32    registered instruction
// - out_pc         out  XLEN  registered PC
// - out_rs1_data   out  XLEN  rs1 operand
// - out_rs2_data   out  XLEN  rs2 operand
// - out_imm        out  XLEN  sign-extended immediate (I/S/B/U/J by opcode, 0 for R-type)
// - out_rd         out  RW    destination index
// - out_reg_write  out  1     instruction writes rd (rd != 0)
// - wb_valid       in   1     writeback strobe
// - wb_rd          in   RW    writeback index
// - wb_data        in   XLEN  writeback data
// BEHAVIOUR
// - Reset: out_valid=0; all out_* data=0; busy[]=0; all registers=0; in_ready=0 during reset cycle.
// - Latency: 1 cycle, in handshake -> out_valid next cycle. Output register states EMPTY/FULL.
// - EMPTY->FULL on in handshake. FULL->EMPTY on out handshake without new in. FULL->FULL on simultaneous out+in handshake (back-to-back).
// - in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst.
// - Usage by opcode: rs1 used by all but LUI/AUIPC/JAL/SYSTEM-imm. rs2 used by R/S/B. rd written by all but S/B/FENCE/ECALL/MRET.
// - hazard: for used rs1/rs2 (index != 0), or for written rd:
//   busy[idx], or (out_valid & out_reg_write & out_rd==idx).
// - busy[out_rd] set on out handshake when out_reg_write. Cleared on wb_valid & wb_rd!=0. Set wins over clear on the same index in the same cycle.
// - Regfile write on wb_valid & wb_rd!=0. x0 read as 0, writes to x0 ignored.
// - Operands sampled at in handshake. Index >= NREG reads 0 and never hazards.
// - Flush: out_valid<=0 next cycle; busy[] untouched (no busy set for flushed instr); in accepted 0 that cycle.
// - Out handshake and flush in the same cycle: handshake completes (busy set), then output empties.
// - Without out_ready, out_* stable while out_valid=1.
// CONFIGURATION
// - WB_BYPASS_EN defined:
//   - wb_valid with wb_rd matching a used rs clears that hazard in the same cycle.
//   - wb_data is forwarded into the sampled operand.
//   - Read-after-writeback costs 0 stall cycles.
// - Undefined:
//   - Hazard clears only after the busy bit drops; regfile is read the cycle after writeback.
//   - Costs 1 extra stall cycle; no forwarding mux.
// TESTING
// - rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, busy all 0; reading x5 after reset -> 0.
// - addi x1,x0,5 issued and consumed; wb x1=5 -> next addi x2,x1,1 stalls until wb.
//   Then out_rs1_data=5. Stall of 0 cycles with WB_BYPASS_EN, 1 without.
// - out_ready=0 for 3 cycles with out_valid=1 -> out_inst/out_pc unchanged, in_ready=0.
//   Then out_ready=1 with in_valid=1 -> back-to-back transfer, no bubble.
// - Write x0 via wb (wb_rd=0, data=0xFFFF_FFFF) -> later rs1=x0 reads 0. lui x0,1 -> out_reg_write=0, no busy set.
// - flush while FULL with busy rd=x3 instr in output -> out_valid=0 next cycle; a following read of x3 issues without stall.
// - Same-cycle out handshake setting busy[4] and wb_rd=4 -> busy[4]=1. sw x4 following stalls until second wb.

Source files
------------

// File: rtl/idu_scoreboard_stage.sv
// Decode stage with regfile (x0=0), immediates and busy scoreboard; 1-cycle latency, in_ready drops on RAW/WAW hazard, flush, or full unconsumed output.
// Optional WB_BYPASS_EN: same-cycle writeback clears the matching rs hazard and is forwarded into the sampled operands.
module idu_scoreboard_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [RW-1:0]   out_rd,
    output logic            out_reg_write,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_mask, set_mask, pend_mask, rs_block, rd_block;

    logic [6:0]      opc;
    logic [2:0]      funct3;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [RW-1:0]   rs1_i, rs2_i, rd_i;
    logic            rs1_ok, rs2_ok, rd_ok;
    logic            use_rs1, use_rs2, wr_rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            hazard, in_hs, out_hs;

    function automatic logic in_range(input logic [4:0] idx);
        return (32'(idx) < NREG);
    endfunction

    assign opc    = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];
    assign rd_f   = in_inst[11:7];
    assign rs1_i  = rs1_f[RW-1:0];
    assign rs2_i  = rs2_f[RW-1:0];
    assign rd_i   = rd_f[RW-1:0];
    assign rs1_ok = (rs1_f != 5'd0) && in_range(rs1_f);
    assign rs2_ok = (rs2_f != 5'd0) && in_range(rs2_f);
    assign rd_ok  = (rd_f != 5'd0) && in_range(rd_f);

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        wr_rd   = 1'b1;
        imm32   = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                use_rs1 = 1'b0;
                imm32   = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                use_rs1 = 1'b0;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_BRANCH: begin
                use_rs2 = 1'b1;
                wr_rd   = 1'b0;
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OPC_STORE: begin
                use_rs2 = 1'b1;
                wr_rd   = 1'b0;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_OP: begin
                use_rs2 = 1'b1;
            end
            OPC_FENCE: begin
                wr_rd = 1'b0;
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_SYSTEM: begin
                // funct3==0 covers ECALL/EBREAK/MRET; funct3[2] selects the CSR zimm forms
                use_rs1 = ~funct3[2];
                wr_rd   = (funct3 != 3'd0);
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            default: ;
        endcase
    end

    always_comb begin
        wb_mask   = '0;
        set_mask  = '0;
        pend_mask = '0;
        for (int i = 1; i < NREG; i++) begin
            wb_mask[i]   = wb_valid && (wb_rd == RW'(i));
            set_mask[i]  = out_hs && out_reg_write && (out_rd == RW'(i));
            pend_mask[i] = out_valid && out_reg_write && (out_rd == RW'(i));
        end
    end

    // The instruction still in the output register has not set its busy bit yet, so it blocks too
`ifdef WB_BYPASS_EN
    assign rs_block = (busy & ~wb_mask) | pend_mask;
`else
    assign rs_block = busy | pend_mask;
`endif
    assign rd_block = busy | pend_mask;

    assign hazard = (use_rs1 && rs1_ok && rs_block[rs1_i]) ||
                    (use_rs2 && rs2_ok && rs_block[rs2_i]) ||
                    (wr_rd && rd_ok && rd_block[rd_i]);

    always_comb begin
        rs1_val = rs1_ok ? regs[rs1_i] : '0;
        rs2_val = rs2_ok ? regs[rs2_i] : '0;
`ifdef WB_BYPASS_EN
        if (rs1_ok && wb_mask[rs1_i]) rs1_val = wb_data;
        if (rs2_ok && wb_mask[rs2_i]) rs2_val = wb_data;
`endif
    end

    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~rst;
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)       state_nxt = EMPTY;
        else if (in_hs)  state_nxt = FULL;
        else if (out_hs) state_nxt = EMPTY;
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_inst      <= '0;
            out_pc        <= '0;
            out_rs1_data  <= '0;
            out_rs2_data  <= '0;
            out_imm       <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else if (in_hs) begin
            out_inst      <= in_inst;
            out_pc        <= in_pc;
            out_rs1_data  <= rs1_val;
            out_rs2_data  <= rs2_val;
            out_imm       <= XLEN'(signed'(imm32));
            out_rd        <= rd_i;
            out_reg_write <= wr_rd && rd_ok;
        end
    end

    // A set on the same index as a writeback clear wins: the newer producer still owns the register
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~wb_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst)             regs[i] <= '0;
            else if (wb_mask[i]) regs[i] <= wb_data;
        end
    end
endmodule
